// File: rtl/clk_div_sel.sv
// clk_div_sel: button-stepped 4-entry divider producing a 1-cycle tick and a divided clock.
module clk_div_sel #(
  parameter int CNT_W = 24,
  parameter int DIV0  = 10,
  parameter int DIV1  = 100,
  parameter int DIV2  = 1000,
  parameter int DIV3  = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_d,
  input  logic       run,
  output logic       tick_o,
  output logic       clk_o,
  output logic [1:0] mode_o
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  logic             btn_prev;
  logic             press;
  assign press = btn_d & ~btn_prev;
  always_comb
    last = mode_o == 2'd0 ? CNT_W'(DIV0 - 1) :
           mode_o == 2'd1 ? CNT_W'(DIV1 - 1) :
           mode_o == 2'd2 ? CNT_W'(DIV2 - 1) : CNT_W'(DIV3 - 1);
  // press wins over terminal count, so a collision never ticks
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_o   <= 2'd0;
      tick_o   <= 1'b0;
      clk_o    <= 1'b0;
      cnt      <= '0;
      btn_prev <= 1'b0;
    end else begin
      btn_prev <= btn_d;
      if (press) begin
        mode_o <= mode_o + 2'd1;
        cnt    <= '0;
        tick_o <= 1'b0;
      end else if (run && cnt == last) begin
        cnt    <= '0;
        tick_o <= 1'b1;
        clk_o  <= ~clk_o;
      end else if (run) begin
        cnt    <= cnt + CNT_W'(1);
        tick_o <= 1'b0;
      end else begin
        tick_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_clk_div_sel.sv
// tb_clk_div_sel: directed checks of reset, mode stepping, pause, collision and held button.
module tb_clk_div_sel;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_d = 1'b0;
  logic       run = 1'b1;
  logic       tick_o;
  logic       clk_o;
  logic [1:0] mode_o;
  int n_chk = 0;
  int n_fail = 0;

  clk_div_sel #(.CNT_W(24), .DIV0(4), .DIV1(6), .DIV2(8), .DIV3(10)) dut (
    .clk(clk), .reset(reset), .btn_d(btn_d), .run(run),
    .tick_o(tick_o), .clk_o(clk_o), .mode_o(mode_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic b);
    reset = 1'b0;
    btn_d = b;
    run   = 1'b1;
    repeat (3) cyc();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic exp_c;
    logic exp_t;
    reset = 1'b0;
    btn_d = 1'b0;
    run   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_chk++;
      if ({mode_o, clk_o, tick_o} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_state cyc %0d: mode=%0d clk_o=%b tick=%b, want 0 0 0", i, mode_o, clk_o, tick_o);
      end
    end
    reset = 1'b1;
    exp_c = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      exp_t = (i % 4 == 3);
      if (exp_t) exp_c = ~exp_c;
      n_chk++;
      if (tick_o !== exp_t || clk_o !== exp_c || mode_o !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_ticks cyc %0d: tick=%b clk_o=%b mode=%0d, want %b %b 0", i, tick_o, clk_o, mode_o, exp_t, exp_c);
      end
    end
  endtask

  task automatic test_modes();
    logic [1:0] exp_m;
    do_reset(1'b0);
    run = 1'b0;
    for (int p = 0; p < 5; p++) begin
      exp_m = 2'((p + 1) % 4);
      btn_d = 1'b1;
      for (int k = 0; k < 5; k++) begin
        cyc();
        if (k == 2) btn_d = 1'b0;
        n_chk++;
        if (mode_o !== exp_m || tick_o !== 1'b0 || clk_o !== 1'b0) begin
          n_fail++;
          $display("FAIL modes press %0d cyc %0d: mode=%0d tick=%b clk_o=%b, want %0d 0 0", p, k, mode_o, tick_o, clk_o, exp_m);
        end
      end
    end
  endtask

  task automatic test_pause();
    do_reset(1'b1);
    cyc();
    btn_d = 1'b0;
    n_chk++;
    if (mode_o !== 2'd1) begin
      n_fail++;
      $display("FAIL pause_mode: mode=%0d, want 1", mode_o);
    end
    repeat (3) cyc();
    run = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      n_chk++;
      if (tick_o !== 1'b0 || clk_o !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_hold cyc %0d: tick=%b clk_o=%b, want 0 0", i, tick_o, clk_o);
      end
    end
    run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      n_chk++;
      if (tick_o !== (i == 2 || i == 8) || clk_o !== (i >= 2 && i < 8)) begin
        n_fail++;
        $display("FAIL pause_resume cyc %0d: tick=%b clk_o=%b, want %b %b", i, tick_o, clk_o, i == 2 || i == 8, i >= 2 && i < 8);
      end
    end
  endtask

  task automatic test_collision();
    do_reset(1'b0);
    repeat (3) cyc();
    btn_d = 1'b1;
    cyc();
    btn_d = 1'b0;
    n_chk++;
    if (tick_o !== 1'b0 || mode_o !== 2'd1 || clk_o !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_edge: tick=%b mode=%0d clk_o=%b, want 0 1 0", tick_o, mode_o, clk_o);
    end
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_chk++;
      if (tick_o !== (i == 5) || clk_o !== (i == 5)) begin
        n_fail++;
        $display("FAIL collision_next cyc %0d: tick=%b clk_o=%b, want %b %b", i, tick_o, clk_o, i == 5, i == 5);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      btn_d = (i % 2 == 0);
      cyc();
    end
    btn_d = 1'b0;
    n_chk++;
    if (mode_o !== 2'd3) begin
      n_fail++;
      $display("FAIL midrst_mode3: mode=%0d, want 3", mode_o);
    end
    for (int i = 0; i < 17; i++) begin
      cyc();
      n_chk++;
      if (tick_o !== (i == 9) || clk_o !== (i >= 9)) begin
        n_fail++;
        $display("FAIL midrst_run cyc %0d: tick=%b clk_o=%b, want %b %b", i, tick_o, clk_o, i == 9, i >= 9);
      end
    end
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    n_chk++;
    if ({mode_o, clk_o, tick_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_clear: mode=%0d clk_o=%b tick=%b, want 0 0 0", mode_o, clk_o, tick_o);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_chk++;
      if (tick_o !== (i == 3) || mode_o !== 2'd0) begin
        n_fail++;
        $display("FAIL midrst_tick cyc %0d: tick=%b mode=%0d, want %b 0", i, tick_o, mode_o, i == 3);
      end
    end
  endtask

  task automatic test_held_btn();
    reset = 1'b0;
    btn_d = 1'b1;
    run   = 1'b0;
    repeat (2) cyc();
    n_chk++;
    if (mode_o !== 2'd0) begin
      n_fail++;
      $display("FAIL held_in_reset: mode=%0d, want 0", mode_o);
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_chk++;
      if (mode_o !== 2'd1) begin
        n_fail++;
        $display("FAIL held_step cyc %0d: mode=%0d, want 1", i, mode_o);
      end
    end
    btn_d = 1'b0;
    cyc();
    btn_d = 1'b1;
    cyc();
    n_chk++;
    if (mode_o !== 2'd2) begin
      n_fail++;
      $display("FAIL held_repress: mode=%0d, want 2", mode_o);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_pause();
    test_collision();
    test_reset_mid();
    test_held_btn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
